pipeline_stall_ctrl: RTL

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl_pkg.sv | 26 ++
 rtl/pipeline_stall_ctrl_mdu_cycle_counter.sv | 22 ++
 rtl/pipeline_stall_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared CPU package: stall FSM states, MDU op codes, pipeline control fields
package pipeline_stall_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } stallState_t;

   typedef enum logic {
      MDU_MUL = 1'b0,
      MDU_DIV = 1'b1
   } mduOp_t;

   // Control fields carried down the pipe; a bubble zeroes all of them.
   typedef struct packed {
      logic regWrite;
      logic memRead;
      logic memWrite;
      logic memToReg;
      logic branch;
      logic aluSrc;
   } ctrlFields_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_mdu_cycle_counter.sv
// rtl/pipeline_stall_ctrl_mdu_cycle_counter.sv - 8-bit down-counter pacing multi-cycle MDU stalls
module mdu_cycle_counter
   import pipeline_stall_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] loadValue,
   input  logic       dec,
   output logic [7:0] cnt
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= 8'd0;
      else if (load)
         cnt <= loadValue;
      else if (dec)
         cnt <= cnt - 8'd1;
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - hazard/stall control: load-use, taken branch, multi-cycle MDU
// Optional STALL_COUNT_EN adds a saturating stall_cycles counter output.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_RegRt,
   input  logic [4:0]  IF_ID_RegRs,
   input  logic [4:0]  IF_ID_RegRt,
   input  logic        branch_taken,
   input  logic        mdu_start,
   input  logic        mdu_op,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        ID_EX_Write,
   output logic        ID_EX_Bubble,
   output logic        IF_ID_Flush,
   output logic        EX_MEM_Bubble,
   output logic        mdu_done
`ifdef STALL_COUNT_EN
   ,
   output logic [15:0] stall_cycles
`endif
);

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   stallState_t state, nextState;
   logic [7:0]  cnt;
   logic        cntLoad, cntDec;
   logic        loadUse;

   assign loadUse = ID_EX_MemRead && (ID_EX_RegRt != REG_ZERO) &&
                    ((ID_EX_RegRt == IF_ID_RegRs) || (ID_EX_RegRt == IF_ID_RegRt));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= RUN;
      else
         state <= nextState;
   end

   mdu_cycle_counter u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (cntLoad),
      .loadValue ((mdu_op == MDU_DIV) ? DIV_LOAD : MUL_LOAD),
      .dec       (cntDec),
      .cnt       (cnt)
   );

   // Outputs are gated by reset_n so they read reset values while reset is held.
   always_comb begin
      nextState     = state;
      cntLoad       = 1'b0;
      cntDec        = 1'b0;
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Write   = 1'b1;
      ID_EX_Bubble  = 1'b0;
      IF_ID_Flush   = 1'b0;
      EX_MEM_Bubble = 1'b0;
      mdu_done      = 1'b0;
      if (reset_n) begin
         case (state)
            RUN: begin
               if (branch_taken) begin
                  IF_ID_Flush  = 1'b1;
                  ID_EX_Bubble = 1'b1;
               end else if (mdu_start) begin
                  PC_Write      = 1'b0;
                  IF_ID_Write   = 1'b0;
                  ID_EX_Write   = 1'b0;
                  EX_MEM_Bubble = 1'b1;
                  cntLoad       = 1'b1;
                  nextState     = MDU_BUSY;
               end else if (loadUse) begin
                  PC_Write     = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
               end
            end
            MDU_BUSY: begin
               PC_Write      = 1'b0;
               IF_ID_Write   = 1'b0;
               ID_EX_Write   = 1'b0;
               EX_MEM_Bubble = 1'b1;
               if (cnt > 8'd1) begin
                  cntDec = 1'b1;
               end else begin
                  mdu_done  = 1'b1;
                  nextState = RUN;
               end
            end
            default: nextState = RUN;
         endcase
      end
   end

`ifdef STALL_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_cycles <= 16'd0;
      else if (!PC_Write && (stall_cycles != 16'hFFFF))
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule
